cc_cond_unit: RTL
=================

# cc_cond_unit

Condition-code register and branch/move condition evaluator for the Y86 execute stage. It sits directly downstream of the ALU and consumes each ALU result (`out`, `of`, function select). It maintains the architectural ZF/SF/OF flags and answers condition queries from the jXX/cmovXX path through a valid/ready request and a registered one-cycle response.

## Interface
Parameters:
- `W`, 64: ALU data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result on `alu_out`/`alu_of` is valid this cycle
- `alu_fn`  in  2  ALU select: 00 add, 01 sub, 10 and, 11 xor
- `alu_out`  in  W  signed ALU result
- `alu_of`  in  1  ALU overflow flag
- `set_cc`  in  1  instruction is OPq; flags update permitted
- `stall`  in  1  execute stage stalled; blocks flag update
- `exc_suppress`  in  1  later stage holds an exception; blocks flag update
- `cond_valid`  in  1  condition query request
- `cond_fn`  in  4  Y86 ifun of jXX/cmovXX
- `cond_ready`  out  1  query accepted this cycle
- `cnd_valid`  out  1  one-cycle pulse; `cnd` valid
- `cnd`  out  1  condition result
- `cnd_err`  out  1  `cond_fn` was illegal (with `cnd_valid`)
- `cc`  out  3  {ZF, SF, OF}, registered

## Operation
- Flag update `upd = alu_valid & set_cc & ~stall & ~exc_suppress`.
- `next_cc`: ZF = (alu_out == 0); SF = alu_out[W-1]; OF = alu_of when alu_fn is 00 or 01, and forced 0 for 10 and 11.
- When `upd` is high, `cc <= next_cc`. Otherwise `cc` holds.
- Conditions (S^O = SF xor OF):
  - 0 always → 1
  - 1 le → (S^O)|ZF
  - 2 l → S^O
  - 3 e → ZF
  - 4 ne → ~ZF
  - 5 ge → ~(S^O)
  - 6 g → ~(S^O)&~ZF
- `cond_fn` 7–15 are illegal: `cnd` = 0, `cnd_err` = 1.
- A query is accepted when `cond_valid & cond_ready`. It is evaluated against the flag source chosen under Configuration.
- There is no response backpressure. `cnd_valid` is a single-cycle pulse per accepted query.
- `stall` does not block queries.
- `exc_suppress` and `stall` both block only the flag update.

## Timing
- Reset values: `cc` = 3'b100 (ZF=1); `cnd_valid` = 0; `cnd` = 0; `cnd_err` = 0.
- Reset asserted mid-operation clears the pending response immediately. No pulse appears after reset is released.
- Flag latency: `cc` reflects an update on the edge after `upd`.
- Query latency: 1 cycle. Accepted at edge N, then `cnd_valid`/`cnd`/`cnd_err` are valid during cycle N+1.
- Back-to-back queries on consecutive cycles yield consecutive pulses.
- Two states per response slot, IDLE and RESP:
  - IDLE → RESP on accept.
  - RESP → RESP on accept.
  - RESP → IDLE otherwise.
- `cond_ready` is combinational from `upd` (see Configuration). It never depends on `cond_valid`.

## Configuration
- `CC_BYPASS_EN` defined: `cond_ready` = 1 always. A query coincident with `upd` evaluates against `next_cc` (forwarding). Otherwise it evaluates against `cc`.
- `CC_BYPASS_EN` undefined: `cond_ready` = ~`upd`. A query coincident with a flag update is refused that cycle and must be held by the requester. Accepted queries always evaluate against `cc`.

## Structure
- Shared package `y86_pkg` holds:
  - ALU function codes (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_XOR`)
  - condition codes `C_ALWAYS`..`C_G`
  - CC bit indices `CC_ZF`/`CC_SF`/`CC_OF`
  - `CC_RESET` = 3'b100
- One combinational sub-module `cond_eval` (inputs cc[2:0] and fn[3:0]; outputs cnd and err). It is reused later by the pipelined cmov path.

## Test plan
- Reset: drive `rst_n`=0 mid-query, then release → `cc`=100 and `cnd_valid`=0. Then query fn=3 (e) → `cnd`=1 next cycle.
- Overflow add: fn=00, out=0x8000000000000000, of=1, set_cc=1 → `cc`=011. Then query fn=2 (l) → `cnd`=0; query fn=1 (le) → `cnd`=0.
- Logic forces OF: fn=11, out=0, alu_of=1 → `cc`=100. Then query fn=6 (g) → `cnd`=0; query fn=4 (ne) → `cnd`=0.
- Blocked update: sub with out=5, set_cc=1 and `stall`=1, then repeat with `exc_suppress`=1 → `cc` unchanged from its prior value both times.
- Coincident update and query: prior `cc`=100, sub with out=-3, query fn=2 in the same cycle.
  - With `CC_BYPASS_EN`: accepted, `cnd`=1.
  - Without it: `cond_ready`=0; the held query is accepted next cycle with `cnd`=1.
- Illegal fn=9 plus back-to-back fn=0 → pulse 1: `cnd`=0, `cnd_err`=1. Pulse 2 on the next cycle: `cnd`=1, `cnd_err`=0.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86 execute stage.
//   - ALU function select codes (alu_fn)
//   - jXX/cmovXX condition codes (ifun)
//   - bit positions inside the {ZF, SF, OF} condition-code vector
//   - CC_RESET value loaded into the condition-code register on reset
//   - resp_state_t: state of the condition-response slot
package y86_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: purely combinational Y86 condition evaluator.
// Ports:
//   cc  in  3  {ZF, SF, OF}
//   fn  in  4  jXX/cmovXX ifun
//   cnd out 1  condition result (0 for illegal fn)
//   err out 1  fn is not a legal condition code (7..15)
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] fn,
  output logic       cnd,
  output logic       err
);

  logic zf;
  logic lt;

  assign zf = cc[CC_ZF];
  // Signed "less than" after a compare is SF xor OF.
  assign lt = cc[CC_SF] ^ cc[CC_OF];

  always_comb begin
    cnd = 1'b0;
    err = 1'b0;
    case (fn)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: condition-code register plus jXX/cmovXX condition query
// port for the Y86 execute stage.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   alu_valid/alu_fn/alu_out/alu_of   ALU result feeding the flags
//   set_cc, stall, exc_suppress        flag-update qualifiers
//   cond_valid/cond_fn/cond_ready      condition query request handshake
//   cnd_valid/cnd/cnd_err              registered one-cycle response pulse
//   cc                                 architectural {ZF, SF, OF}
// Build option: define CC_BYPASS_EN to always accept queries and forward
// the flags being written this cycle to a coincident query. Without it, a
// query that collides with a flag update is refused for that cycle.
module cc_cond_unit
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alu_valid,
  input  logic [1:0]   alu_fn,
  input  logic [W-1:0] alu_out,
  input  logic         alu_of,
  input  logic         set_cc,
  input  logic         stall,
  input  logic         exc_suppress,
  input  logic         cond_valid,
  input  logic [3:0]   cond_fn,
  output logic         cond_ready,
  output logic         cnd_valid,
  output logic         cnd,
  output logic         cnd_err,
  output logic [2:0]   cc
);

  logic        upd;
  logic [2:0]  next_cc;
  logic [2:0]  eval_cc;
  logic        accept;
  logic        eval_cnd;
  logic        eval_err;

  resp_state_t state_q, state_d;
  logic        cnd_q, cnd_d;
  logic        err_q, err_d;

  assign upd = alu_valid & set_cc & ~stall & ~exc_suppress;

  // Logical ops never overflow, so OF is forced clear for AND/XOR.
  always_comb begin
    next_cc        = '0;
    next_cc[CC_ZF] = (alu_out == '0);
    next_cc[CC_SF] = alu_out[W-1];
    next_cc[CC_OF] = ((alu_fn == ALU_ADD) || (alu_fn == ALU_SUB)) ? alu_of : 1'b0;
  end

`ifdef CC_BYPASS_EN
  // Forward the flags being written so a coincident query sees them.
  assign cond_ready = 1'b1;
  assign eval_cc    = upd ? next_cc : cc;
`else
  // Refuse queries while the flags are changing; requester holds the query.
  assign cond_ready = ~upd;
  assign eval_cc    = cc;
`endif

  assign accept = cond_valid & cond_ready;

  cond_eval u_cond_eval (
    .cc  (eval_cc),
    .fn  (cond_fn),
    .cnd (eval_cnd),
    .err (eval_err)
  );

  // Condition-code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc <= CC_RESET;
    end else if (upd) begin
      cc <= next_cc;
    end
  end

  // Response slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnd_q   <= cnd_d;
      err_q   <= err_d;
    end
  end

  // Every accepted query yields exactly one pulse in the following cycle;
  // result bits are cleared outside a pulse.
  always_comb begin
    state_d = S_IDLE;
    cnd_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = accept ? S_RESP : S_IDLE;
      S_RESP: state_d = accept ? S_RESP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      cnd_d = eval_cnd;
      err_d = eval_err;
    end
  end

  assign cnd_valid = (state_q == S_RESP);
  assign cnd       = cnd_q;
  assign cnd_err   = err_q;

endmodule
